hazard_unit_mc: RTL and testbench

- Next-generation hazard unit for the 5-stage pipeline (F/D/E/M/W), parametrised in register-address width, zero-register handling and multi-cycle execute latency.
- Adds three things to the base forwarding, load-use and branch-flush logic:
  - a sequential multi-cycle-op stall controller;
  - a data-memory wait stall;
  - saturating stall and flush performance counters.
- Sits beside the datapath and drives the pipeline-register enables, flushes and E-stage forwarding muxes.

---
 rtl/hazard_pkg.sv | 14 +
 rtl/mc_stall_ctrl.sv | 68 ++++++
 rtl/hazard_unit_mc.sv | 123 ++++++++++++
 tb/tb_hazard_unit_mc.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared encodings for the multi-cycle hazard unit: forward-mux selects and
// the multi-cycle controller state type.
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mcState_t;

endpackage

// File: rtl/mc_stall_ctrl.sv
// Multi-cycle execute controller: holds an op in E for MC_LAT cycles,
// freezing its countdown while the data memory is stalling the pipe.
module mc_stall_ctrl #(
  parameter int MC_LAT = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic MultiCycleE,
  input  logic memStall,
  output logic mcStall,
  output logic McBusy
);
  import hazard_pkg::*;

  localparam bit         MC_EN    = (MC_LAT > 1);
  localparam logic [7:0] CNT_INIT = (MC_LAT > 1) ? 8'(MC_LAT - 2) : 8'd0;

  mcState_t   state_r;
  mcState_t   stateNext_s;
  logic [7:0] cnt_r;
  logic [7:0] cntNext_s;

  // State and countdown registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      cnt_r   <= 8'd0;
    end else begin
      state_r <= stateNext_s;
      cnt_r   <= cntNext_s;
    end
  end

  // Next-state and stall request; the cycle with cnt==0 is the op's last in E
  always_comb begin
    stateNext_s = state_r;
    cntNext_s   = cnt_r;
    mcStall     = 1'b0;
    case (state_r)
      IDLE: begin
        if (MC_EN && MultiCycleE && !memStall) begin
          mcStall     = 1'b1;
          stateNext_s = BUSY;
          cntNext_s   = CNT_INIT;
        end else begin
          mcStall     = 1'b0;
        end
      end
      BUSY: begin
        if (memStall) begin
          mcStall     = 1'b0;
        end else if (cnt_r != 8'd0) begin
          mcStall     = 1'b1;
          cntNext_s   = cnt_r - 8'd1;
        end else begin
          stateNext_s = IDLE;
        end
      end
      default: begin
        stateNext_s = IDLE;
        cntNext_s   = 8'd0;
      end
    endcase
  end

  assign McBusy = (state_r == BUSY);

endmodule

// File: rtl/hazard_unit_mc.sv
// Five-stage pipeline hazard unit: E-stage forwarding, prioritised
// stall/flush generation and saturating stall/flush event counters.
module hazard_unit_mc #(
  parameter int REG_AW   = 4,
  parameter int ZERO_REG = 1,
  parameter int MC_LAT   = 4,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  input  logic              RegWriteE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              LoadE,
  input  logic              MultiCycleE,
  input  logic              PCSrcE,
  input  logic              MemAccessM,
  input  logic              MemReadyM,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushM,
  output logic              FlushW,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              McBusy,
  output logic [CNT_W-1:0]  StallCount,
  output logic [CNT_W-1:0]  FlushCount
);
  import hazard_pkg::*;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic memStall_s;
  logic mcStall_s;
  logic lwStall_s;
  logic flushAccept_s;

  // Register 0 is only special when it is hardwired to zero
  function automatic logic nz(input logic [REG_AW-1:0] r);
    return (ZERO_REG == 0) || (r != {REG_AW{1'b0}});
  endfunction

  function automatic logic [1:0] fwdSel(input logic [REG_AW-1:0] rs);
    if (rs == RdM && RegWriteM && nz(rs))      return FWD_MEM;
    else if (rs == RdW && RegWriteW && nz(rs)) return FWD_WB;
    else                                       return FWD_RF;
  endfunction

  assign ForwardAE  = fwdSel(Rs1E);
  assign ForwardBE  = fwdSel(Rs2E);
  assign memStall_s = MemAccessM & ~MemReadyM;
  // A taken branch makes the D instruction wrong-path, so no load-use stall
  assign lwStall_s  = LoadE & RegWriteE & nz(RdE) &
                      ((Rs1D == RdE) | (Rs2D == RdE)) & ~PCSrcE;

  mc_stall_ctrl #(.MC_LAT(MC_LAT)) u_mc (
    .clk         (clk),
    .reset_n     (reset_n),
    .MultiCycleE (MultiCycleE),
    .memStall    (memStall_s),
    .mcStall     (mcStall_s),
    .McBusy      (McBusy)
  );

  // Priority resolution; a memory wait freezes E so a pending branch re-asserts later
  always_comb begin
    StallF        = 1'b0;
    StallD        = 1'b0;
    StallE        = 1'b0;
    StallM        = 1'b0;
    FlushD        = 1'b0;
    FlushE        = 1'b0;
    FlushM        = 1'b0;
    FlushW        = 1'b0;
    flushAccept_s = 1'b0;
    if (memStall_s) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (mcStall_s) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      FlushM = 1'b1;
    end else if (PCSrcE) begin
      FlushD        = 1'b1;
      FlushE        = 1'b1;
      flushAccept_s = 1'b1;
    end else if (lwStall_s) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end else begin
      flushAccept_s = 1'b0;
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      StallCount <= {CNT_W{1'b0}};
      FlushCount <= {CNT_W{1'b0}};
    end else begin
      if (StallF && (StallCount != CNT_MAX)) StallCount <= StallCount + CNT_ONE;
      if (flushAccept_s && (FlushCount != CNT_MAX)) FlushCount <= FlushCount + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Scoreboard bench for hazard_unit_mc: the driver queues per-cycle expectations,
// a negedge monitor pops and compares them against three parameter variants.
module tb_hazard_unit_mc;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       RegWriteE, RegWriteM, RegWriteW, LoadE, MultiCycleE, PCSrcE;
  logic       MemAccessM, MemReadyM;

  logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW, McBusy;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [15:0] StallCount, FlushCount;

  logic        zStallF, zStallD, zStallE, zStallM, zFlushD, zFlushE, zFlushM, zFlushW, zMcBusy;
  logic [1:0]  zForwardAE, zForwardBE;
  logic [15:0] zStallCount, zFlushCount;

  logic        sStallF, sStallD, sStallE, sStallM, sFlushD, sFlushE, sFlushM, sFlushW, sMcBusy;
  logic [1:0]  sForwardAE, sForwardBE;
  logic [3:0]  sStallCount, sFlushCount;

  always #5 clk = ~clk;

  hazard_unit_mc dut (
    .clk(clk), .reset_n(reset_n), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteE(RegWriteE), .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW), .LoadE(LoadE), .MultiCycleE(MultiCycleE), .PCSrcE(PCSrcE),
    .MemAccessM(MemAccessM), .MemReadyM(MemReadyM), .StallF(StallF), .StallD(StallD),
    .StallE(StallE), .StallM(StallM), .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
    .FlushW(FlushW), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .McBusy(McBusy),
    .StallCount(StallCount), .FlushCount(FlushCount));

  hazard_unit_mc #(.ZERO_REG(0)) dutZ (
    .clk(clk), .reset_n(reset_n), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteE(RegWriteE), .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW), .LoadE(LoadE), .MultiCycleE(MultiCycleE), .PCSrcE(PCSrcE),
    .MemAccessM(MemAccessM), .MemReadyM(MemReadyM), .StallF(zStallF), .StallD(zStallD),
    .StallE(zStallE), .StallM(zStallM), .FlushD(zFlushD), .FlushE(zFlushE), .FlushM(zFlushM),
    .FlushW(zFlushW), .ForwardAE(zForwardAE), .ForwardBE(zForwardBE), .McBusy(zMcBusy),
    .StallCount(zStallCount), .FlushCount(zFlushCount));

  hazard_unit_mc #(.CNT_W(4)) dutS (
    .clk(clk), .reset_n(reset_n), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteE(RegWriteE), .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW), .LoadE(LoadE), .MultiCycleE(MultiCycleE), .PCSrcE(PCSrcE),
    .MemAccessM(MemAccessM), .MemReadyM(MemReadyM), .StallF(sStallF), .StallD(sStallD),
    .StallE(sStallE), .StallM(sStallM), .FlushD(sFlushD), .FlushE(sFlushE), .FlushM(sFlushM),
    .FlushW(sFlushW), .ForwardAE(sForwardAE), .ForwardBE(sForwardBE), .McBusy(sMcBusy),
    .StallCount(sStallCount), .FlushCount(sFlushCount));

  localparam int S_FA = 0, S_FAZ = 1, S_STALLS = 2, S_FLUSH = 3, S_BUSY = 4;
  localparam int S_SC = 5, S_FC = 6, S_SCSAT = 7, S_FB = 8;

  typedef struct {
    int          cyc;
    int          sig;
    logic [15:0] val;
    string       name;
  } expect_t;

  expect_t q[$];
  int      cyc = 0;
  int      nChecks = 0;
  int      nPass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] getSig(input int sig);
    case (sig)
      S_FA:     return {14'd0, ForwardAE};
      S_FB:     return {14'd0, ForwardBE};
      S_FAZ:    return {14'd0, zForwardAE};
      S_STALLS: return {12'd0, StallF, StallD, StallE, StallM};
      S_FLUSH:  return {12'd0, FlushD, FlushE, FlushM, FlushW};
      S_BUSY:   return {15'd0, McBusy};
      S_SC:     return StallCount;
      S_FC:     return FlushCount;
      S_SCSAT:  return {12'd0, sStallCount};
      default:  return 16'hdead;
    endcase
  endfunction

  // Monitor: compare every expectation queued for the current cycle
  always @(negedge clk) begin
    expect_t e;
    logic [15:0] act;
    while (q.size() != 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      nChecks++;
      act = getSig(e.sig);
      if (e.cyc != cyc)
        $display("FAIL %s: expectation for cycle %0d reached monitor at cycle %0d", e.name, e.cyc, cyc);
      else if (act !== e.val)
        $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", e.name, cyc, act, e.val);
      else
        nPass++;
    end
  end

  task automatic expectV(input int sig, input logic [15:0] val, input string name);
    expect_t e;
    e.cyc = cyc; e.sig = sig; e.val = val; e.name = name;
    q.push_back(e);
  endtask

  task automatic nextCyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    Rs1D = 4'd0; Rs2D = 4'd0; Rs1E = 4'd0; Rs2E = 4'd0; RdE = 4'd0; RdM = 4'd0; RdW = 4'd0;
    RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0; LoadE = 1'b0;
    MultiCycleE = 1'b0; PCSrcE = 1'b0; MemAccessM = 1'b0; MemReadyM = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    clr();
    nextCyc();
    expectV(S_STALLS, 16'h0, "rst_stalls"); expectV(S_FLUSH, 16'h0, "rst_flush");
    expectV(S_BUSY, 16'h0, "rst_busy");     expectV(S_SC, 16'h0, "rst_sc");
    expectV(S_FC, 16'h0, "rst_fc");         expectV(S_FA, 16'h0, "rst_fa");
    nextCyc(); reset_n = 1'b1;

    // Forwarding
    nextCyc(); Rs1E = 4'd3; RdM = 4'd3; RegWriteM = 1'b1; RdW = 4'd3; RegWriteW = 1'b1; Rs2E = 4'd4;
    expectV(S_FA, 16'h2, "fwd_m_prio"); expectV(S_FAZ, 16'h2, "fwdz_m_prio"); expectV(S_FB, 16'h0, "fwdb_none");
    nextCyc(); RegWriteM = 1'b0;
    expectV(S_FA, 16'h1, "fwd_w");
    nextCyc(); Rs1E = 4'd0; RdM = 4'd0; RegWriteM = 1'b1; RdW = 4'd0; Rs2E = 4'd0;
    expectV(S_FA, 16'h0, "fwd_r0_zero"); expectV(S_FAZ, 16'h2, "fwdz_r0_ordinary"); expectV(S_FB, 16'h0, "fwdb_r0");
    nextCyc(); Rs1E = 4'd2; RdM = 4'd2; Rs2E = 4'd6; RdW = 4'd6;
    expectV(S_FA, 16'h2, "fwda_m"); expectV(S_FB, 16'h1, "fwdb_w"); expectV(S_STALLS, 16'h0, "fwd_nostall");

    // Load-use, then load-use overridden by a taken branch
    nextCyc(); clr(); LoadE = 1'b1; RegWriteE = 1'b1; RdE = 4'd5; Rs2D = 4'd5;
    expectV(S_STALLS, 16'hC, "lw_stalls"); expectV(S_FLUSH, 16'h4, "lw_flush");
    nextCyc(); clr();
    expectV(S_STALLS, 16'h0, "lw_release"); expectV(S_SC, 16'd1, "lw_sc");
    nextCyc(); LoadE = 1'b1; RegWriteE = 1'b1; RdE = 4'd5; Rs2D = 4'd5; PCSrcE = 1'b1;
    expectV(S_STALLS, 16'h0, "br_stalls"); expectV(S_FLUSH, 16'hC, "br_flush");
    nextCyc(); clr();
    expectV(S_FC, 16'd1, "br_fc"); expectV(S_SC, 16'd1, "br_sc");
    nextCyc(); LoadE = 1'b1; RegWriteE = 1'b1;
    expectV(S_STALLS, 16'h0, "lw_r0_nostall");
    nextCyc(); clr();
    expectV(S_SC, 16'd1, "lw_r0_sc");

    // Multi-cycle op, MC_LAT=4
    nextCyc(); MultiCycleE = 1'b1;
    expectV(S_STALLS, 16'hE, "mc1_stalls"); expectV(S_FLUSH, 16'h2, "mc1_flush"); expectV(S_BUSY, 16'h0, "mc1_busy");
    nextCyc();
    expectV(S_STALLS, 16'hE, "mc2_stalls"); expectV(S_BUSY, 16'h1, "mc2_busy"); expectV(S_SC, 16'd2, "mc2_sc");
    nextCyc();
    expectV(S_STALLS, 16'hE, "mc3_stalls"); expectV(S_BUSY, 16'h1, "mc3_busy"); expectV(S_SC, 16'd3, "mc3_sc");
    nextCyc();
    expectV(S_STALLS, 16'h0, "mc4_stalls"); expectV(S_FLUSH, 16'h0, "mc4_flush");
    expectV(S_BUSY, 16'h1, "mc4_busy"); expectV(S_SC, 16'd4, "mc4_sc");
    nextCyc(); clr();
    expectV(S_BUSY, 16'h0, "mc5_busy"); expectV(S_STALLS, 16'h0, "mc5_stalls"); expectV(S_SC, 16'd4, "mc5_sc");

    // Memory wait during BUSY at cnt=1; pending branch ignored while memory stalls
    nextCyc(); MultiCycleE = 1'b1;
    expectV(S_STALLS, 16'hE, "mw1_stalls");
    nextCyc();
    expectV(S_STALLS, 16'hE, "mw2_stalls"); expectV(S_SC, 16'd5, "mw2_sc");
    nextCyc(); MemAccessM = 1'b1; MemReadyM = 1'b0;
    expectV(S_STALLS, 16'hF, "mw3_stalls"); expectV(S_FLUSH, 16'h1, "mw3_flush"); expectV(S_BUSY, 16'h1, "mw3_busy");
    nextCyc(); PCSrcE = 1'b1;
    expectV(S_STALLS, 16'hF, "mw4_stalls"); expectV(S_FLUSH, 16'h1, "mw4_flush"); expectV(S_SC, 16'd7, "mw4_sc");
    nextCyc(); MemAccessM = 1'b0; PCSrcE = 1'b0;
    expectV(S_STALLS, 16'hE, "mw5_stalls"); expectV(S_FLUSH, 16'h2, "mw5_flush"); expectV(S_FC, 16'd1, "mw5_fc");
    nextCyc();
    expectV(S_STALLS, 16'h0, "mw6_stalls"); expectV(S_BUSY, 16'h1, "mw6_busy"); expectV(S_SC, 16'd9, "mw6_sc");
    nextCyc(); clr();
    expectV(S_BUSY, 16'h0, "mw7_busy"); expectV(S_STALLS, 16'h0, "mw7_stalls");

    // Async reset while BUSY with cnt=1
    nextCyc(); MultiCycleE = 1'b1;
    expectV(S_STALLS, 16'hE, "rb1_stalls");
    nextCyc();
    expectV(S_BUSY, 16'h1, "rb2_busy"); expectV(S_SC, 16'd10, "rb2_sc");
    nextCyc(); clr(); reset_n = 1'b0;
    expectV(S_BUSY, 16'h0, "rb3_busy"); expectV(S_SC, 16'h0, "rb3_sc"); expectV(S_FC, 16'h0, "rb3_fc");
    expectV(S_STALLS, 16'h0, "rb3_stalls"); expectV(S_SCSAT, 16'h0, "rb3_scsat");
    nextCyc(); reset_n = 1'b1;
    expectV(S_BUSY, 16'h0, "rb4_busy"); expectV(S_STALLS, 16'h0, "rb4_stalls");
    nextCyc();
    expectV(S_BUSY, 16'h0, "rb5_busy"); expectV(S_STALLS, 16'h0, "rb5_stalls"); expectV(S_SC, 16'h0, "rb5_sc");

    // 20 consecutive load-use stalls; 4-bit counter saturates at 15
    for (int i = 0; i < 20; i++) begin
      nextCyc(); LoadE = 1'b1; RegWriteE = 1'b1; RdE = 4'd5; Rs1D = 4'd5;
      expectV(S_SCSAT, (i < 15) ? 16'(i) : 16'd15, "sat_sc");
      if (i == 0) expectV(S_FLUSH, 16'h4, "sat_flush");
    end
    nextCyc(); clr();
    expectV(S_SCSAT, 16'd15, "sat_hold1"); expectV(S_SC, 16'd20, "sat_main_sc");
    nextCyc();
    expectV(S_SCSAT, 16'd15, "sat_hold2");

    nextCyc();
    nextCyc();
    if (q.size() != 0) begin
      nChecks++;
      $display("FAIL scoreboard_drain: %0d expectations left unchecked, expected 0", q.size());
    end
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
